// File: rtl/exp_softmax_norm.sv
// Softmax normalisation stage: buffers one frame of exp values while summing
// them, then divides each stored value by the frame sum with a sequential
// restoring divider and emits Q0.OUT_W probabilities in arrival order.
module exp_softmax_norm #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 16,
  parameter int OUT_W  = 16,
  localparam int SUM_W = DATA_W + $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] iData,
  input  logic              iDataValid,
  input  logic              iLast,
  output logic              iReady,
  output logic [OUT_W-1:0]  oData,
  output logic              oDataValid,
  output logic              oLast,
  output logic              oBusy,
  output logic              oErr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IT_W  = $clog2(OUT_W);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_DIV_LOAD = 3'd2,
    S_DIV_ITER = 3'd3,
    S_DIV_OUT  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   wptr_q, wptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [SUM_W-1:0]   rem_q, rem_d;
  logic [OUT_W-1:0]   quo_q, quo_d;
  logic [IT_W-1:0]    it_q, it_d;
  logic [OUT_W-1:0]   odata_q, odata_d;
  logic               ovalid_q, ovalid_d;
  logic               olast_q, olast_d;
  logic               err_q, err_d;

  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               ready_s;
  logic               accept_s;
  logic               drop_s;
  logic               full_s;
  logic [PTR_W-1:0]   wr_addr_s;
  logic [SUM_W-1:0]   data_ext_s;
  logic [SUM_W-1:0]   rd_ext_s;
  logic [SUM_W:0]     shifted_s;
  logic [SUM_W:0]     diff_s;

  assign ready_s    = (state_q == S_IDLE) || (state_q == S_COLLECT);
  assign accept_s   = iDataValid && ready_s;
  assign drop_s     = iDataValid && !ready_s;
  assign full_s     = (state_q == S_COLLECT) && (wptr_q == CNT_W'(DEPTH - 1));
  // A new frame always starts at slot 0, whatever the old write pointer was.
  assign wr_addr_s  = (state_q == S_IDLE) ? {PTR_W{1'b0}} : wptr_q[PTR_W-1:0];
  assign data_ext_s = {{(SUM_W-DATA_W){1'b0}}, iData};
  assign rd_ext_s   = {{(SUM_W-DATA_W){1'b0}}, mem_q[rptr_q]};
  // Remainder is kept below the sum, so one extra bit covers the doubled value.
  assign shifted_s  = {rem_q, 1'b0};
  assign diff_s     = shifted_s - {1'b0, sum_q};

  assign iReady     = ready_s;
  assign oData      = odata_q;
  assign oDataValid = ovalid_q;
  assign oLast      = olast_q;
  assign oBusy      = (state_q != S_IDLE);
  assign oErr       = err_q;

  // Frame buffer write; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_addr_s] <= iData;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sum_q    <= {SUM_W{1'b0}};
      wptr_q   <= {CNT_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      rptr_q   <= {PTR_W{1'b0}};
      rem_q    <= {SUM_W{1'b0}};
      quo_q    <= {OUT_W{1'b0}};
      it_q     <= {IT_W{1'b0}};
      odata_q  <= {OUT_W{1'b0}};
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      wptr_q   <= wptr_d;
      cnt_q    <= cnt_d;
      rptr_q   <= rptr_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      it_q     <= it_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      err_q    <= err_d;
    end
  end

  // Next-state, collection, division and output logic.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    wptr_d   = wptr_q;
    cnt_d    = cnt_q;
    rptr_d   = rptr_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    it_d     = it_q;
    odata_d  = odata_q;
    ovalid_d = 1'b0;
    olast_d  = 1'b0;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          err_d  = 1'b0;
          sum_d  = data_ext_s;
          wptr_d = CNT_W'(1);
          if (iLast) begin
            cnt_d   = CNT_W'(1);
            rptr_d  = {PTR_W{1'b0}};
            state_d = S_DIV_LOAD;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (accept_s) begin
          sum_d  = sum_q + data_ext_s;
          wptr_d = wptr_q + CNT_W'(1);
          if (iLast || full_s) begin
            cnt_d   = wptr_q + CNT_W'(1);
            rptr_d  = {PTR_W{1'b0}};
            state_d = S_DIV_LOAD;
          end else begin
            state_d = S_COLLECT;
          end
          if (full_s && !iLast) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_DIV_LOAD: begin
        // x <= sum, so x itself is the partial remainder after the integer
        // quotient bit; only the OUT_W fractional bits remain to be produced.
        rem_d   = rd_ext_s;
        quo_d   = {OUT_W{1'b0}};
        it_d    = IT_W'(OUT_W - 1);
        state_d = S_DIV_ITER;
      end
      S_DIV_ITER: begin
        if (shifted_s >= {1'b0, sum_q}) begin
          rem_d = diff_s[SUM_W-1:0];
          quo_d = {quo_q[OUT_W-2:0], 1'b1};
        end else begin
          rem_d = shifted_s[SUM_W-1:0];
          quo_d = {quo_q[OUT_W-2:0], 1'b0};
        end
        if (it_q == {IT_W{1'b0}}) begin
          state_d = S_DIV_OUT;
        end else begin
          it_d    = it_q - IT_W'(1);
          state_d = S_DIV_ITER;
        end
      end
      S_DIV_OUT: begin
        ovalid_d = 1'b1;
        olast_d  = (CNT_W'(rptr_q) == (cnt_q - CNT_W'(1)));
        if (sum_q == {SUM_W{1'b0}}) begin
          odata_d = {OUT_W{1'b0}};
          err_d   = 1'b1;
        end else if (rd_ext_s >= sum_q) begin
          odata_d = {OUT_W{1'b1}};
        end else begin
          odata_d = quo_q;
        end
        if (olast_d) begin
          state_d = S_IDLE;
        end else begin
          rptr_d  = rptr_q + PTR_W'(1);
          state_d = S_DIV_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (drop_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
  end

endmodule

// File: tb/tb_exp_softmax_norm.sv
// Scoreboard bench for exp_softmax_norm: the driver pushes expected outputs
// (value, last flag, arrival cycle) computed from plain arithmetic, and a
// separate monitor pops and compares whenever oDataValid is seen.
module tb_exp_softmax_norm;

  localparam int DATA_W = 20;
  localparam int DEPTH  = 16;
  localparam int OUT_W  = 16;
  localparam int LAT    = OUT_W + 2;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] iData;
  logic              iDataValid;
  logic              iLast;
  logic              iReady;
  logic [OUT_W-1:0]  oData;
  logic              oDataValid;
  logic              oLast;
  logic              oBusy;
  logic              oErr;

  typedef struct {
    longint unsigned data;
    bit              last;
    int unsigned     cyc;
  } exp_t;

  exp_t            exp_q [$];
  int unsigned     fr [$];
  int unsigned     cyc;
  int              n_tests;
  int              n_fail;

  exp_softmax_norm #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .iData(iData), .iDataValid(iDataValid),
    .iLast(iLast), .iReady(iReady), .oData(oData), .oDataValid(oDataValid),
    .oLast(oLast), .oBusy(oBusy), .oErr(oErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // free-running cycle counter used for latency checks
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: p = floor(x * 2^OUT_W / sum), capped at 2^OUT_W-1, 0 if sum==0.
  function automatic void push_expected(input int unsigned acc_cyc);
    longint unsigned s;
    longint unsigned q;
    exp_t e;
    s = 0;
    foreach (fr[i]) s += fr[i];
    foreach (fr[i]) begin
      if (s == 0) q = 0;
      else q = (longint'(fr[i]) << OUT_W) / s;
      if (q > (64'd1 << OUT_W) - 1) q = (64'd1 << OUT_W) - 1;
      e.data = q;
      e.last = (i == fr.size() - 1);
      e.cyc  = acc_cyc + LAT * (i + 1);
      exp_q.push_back(e);
    end
  endfunction

  // Drive fr[] as one frame with iLast on the final sample; returns at the
  // falling edge after the last sample was accepted.
  task automatic send_frame();
    int w;
    for (int i = 0; i < fr.size(); i++) begin
      w = 0;
      while (!iReady && w < 400) begin
        @(negedge clk);
        w++;
      end
      if (!iReady) chk("ready_timeout", 0, 1);
      iData      = fr[i][DATA_W-1:0];
      iDataValid = 1'b1;
      iLast      = (i == fr.size() - 1);
      @(posedge clk);
      @(negedge clk);
      iDataValid = 1'b0;
      iLast      = 1'b0;
    end
    push_expected(cyc);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 4000) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_oData"}, oData, 0);
    chk({tag, "_oDataValid"}, oDataValid, 0);
    chk({tag, "_oLast"}, oLast, 0);
    chk({tag, "_oBusy"}, oBusy, 0);
    chk({tag, "_oErr"}, oErr, 0);
    chk({tag, "_iReady"}, iReady, 1);
  endtask

  // monitor: compares every output pulse against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (oLast && !oDataValid) chk("olast_without_valid", oLast, 0);
        if (oDataValid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", oDataValid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("oData", oData, e.data);
            chk("oLast", oLast, e.last);
            chk("out_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int unsigned acc;
    int          bad;
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    iData      = '0;
    iDataValid = 1'b0;
    iLast      = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);

    // single sample saturates
    fr = '{1000};
    send_frame();
    wait_drain();
    chk("single_oErr", oErr, 0);

    // equal quarters, iReady low through division
    fr = '{1, 1, 1, 1};
    send_frame();
    bad = 0;
    for (int i = 0; i < 4 * LAT - 4; i++) begin
      if (iReady !== 1'b0 || oBusy !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("ready_low_in_div", bad, 0);
    wait_drain();

    fr = '{1, 2};
    send_frame();
    wait_drain();
    fr = '{3, 1};
    send_frame();
    wait_drain();

    // overfull frame: 16th forced last, 17th dropped
    for (int i = 0; i < DEPTH + 1; i++) begin
      iData      = 20'd5;
      iDataValid = 1'b1;
      iLast      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (i == DEPTH - 1) acc = cyc;
    end
    iDataValid = 1'b0;
    fr = {};
    for (int i = 0; i < DEPTH; i++) fr.push_back(5);
    push_expected(acc);
    chk("overfull_oErr_early", oErr, 1);
    wait_drain();
    chk("overfull_oErr", oErr, 1);
    fr = '{9};
    send_frame();
    chk("err_cleared", oErr, 0);
    wait_drain();

    // zero sum, then back-to-back single
    fr = '{0, 0};
    send_frame();
    wait_drain();
    chk("zero_sum_oErr", oErr, 1);
    fr = '{7};
    send_frame();
    chk("zero_then_clear", oErr, 0);
    wait_drain();

    // reset during division of the 2nd element
    fr = '{1, 2, 3, 4};
    send_frame();
    repeat (LAT + 7) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_vals("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", iReady, 1);
    repeat (5 * LAT) @(negedge clk);
    fr = '{2, 2};
    send_frame();
    wait_drain();

    // random back-to-back frames
    for (int f = 0; f < 14; f++) begin
      int len;
      len = $urandom_range(1, DEPTH);
      fr = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) fr.push_back($urandom_range(0, 3));
        else fr.push_back($urandom_range(0, (1 << DATA_W) - 1));
      end
      send_frame();
    end
    wait_drain();
    repeat (2 * LAT) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
